// File: rtl/setbit_vec_assembler.sv
// Purpose: rebuild a NUM_PORTS-wide bit mask from a stream of set-bit positions, with count and error flags.
// Latency: result is valid one cycle after the beat carrying in_last is accepted.
// Backpressure: while a result is held, in_ready follows out_ready; in_ready never depends on in_* inputs.
module setbit_vec_assembler #(
    parameter int NUM_PORTS = 8,
    parameter int POS_W     = $clog2(NUM_PORTS),
    parameter int CNT_W     = $clog2(NUM_PORTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [POS_W-1:0]     in_pos,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] out_vec,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_err_dup,
    output logic                 out_err_range
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Frame accumulator
    logic [NUM_PORTS-1:0] acc_vec;
    logic [CNT_W-1:0]     acc_cnt;
    logic                 acc_dup;
    logic                 acc_range;

    // Accumulator with the current beat folded in
    logic [NUM_PORTS-1:0] mrg_vec;
    logic [CNT_W-1:0]     mrg_cnt;
    logic                 mrg_dup;
    logic                 mrg_range;

    logic                 fire;
    logic                 in_range;
    logic                 hit;
    logic [NUM_PORTS-1:0] pos_mask;

    // A held result only blocks the input when downstream is stalled
    assign in_ready  = (state == COLLECT) | out_ready;
    assign fire      = in_valid & in_ready;
    assign out_valid = (state == FULL);

    // Shift-built mask is zero for positions past the vector, so no out-of-range index is ever formed
    assign in_range = ({1'b0, in_pos} < (POS_W + 1)'(NUM_PORTS));
    assign pos_mask = NUM_PORTS'(1) << in_pos;
    assign hit      = |(acc_vec & pos_mask);

    // Fold the current beat into the accumulator; duplicates and out-of-range beats only raise flags
    always_comb begin
        mrg_vec   = acc_vec;
        mrg_cnt   = acc_cnt;
        mrg_dup   = acc_dup;
        mrg_range = acc_range;
        if (!in_range) begin
            mrg_range = 1'b1;
        end else if (hit) begin
            mrg_dup = 1'b1;
        end else begin
            mrg_vec = acc_vec | pos_mask;
            mrg_cnt = acc_cnt + CNT_W'(1);
        end
    end

    // Next state: a new last beat keeps FULL occupied, otherwise a consumed result frees it
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (fire && in_last) state_nxt = FULL;
            end
            FULL: begin
                if (out_ready && !(fire && in_last)) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // Accumulator update and result load; the accumulator clears as the result is captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_vec       <= '0;
            acc_cnt       <= '0;
            acc_dup       <= 1'b0;
            acc_range     <= 1'b0;
            out_vec       <= '0;
            out_count     <= '0;
            out_err_dup   <= 1'b0;
            out_err_range <= 1'b0;
        end else if (fire && in_last) begin
            out_vec       <= mrg_vec;
            out_count     <= mrg_cnt;
            out_err_dup   <= mrg_dup;
            out_err_range <= mrg_range;
            acc_vec       <= '0;
            acc_cnt       <= '0;
            acc_dup       <= 1'b0;
            acc_range     <= 1'b0;
        end else if (fire) begin
            acc_vec   <= mrg_vec;
            acc_cnt   <= mrg_cnt;
            acc_dup   <= mrg_dup;
            acc_range <= mrg_range;
        end
    end

endmodule

// File: doc/setbit_vec_assembler.md
Name: setbit_vec_assembler

Overview:
- Companion to the set-bit position finder; performs the inverse transform.
- Accepts a valid/ready stream of bit positions, one per beat, terminated by in_last.
- Rebuilds the NUM_PORTS-wide vector with those bits set, plus a population count and error flags.
- Sits downstream of any block that serialises set-bit indices, such as port-grant or request lists, and restores the parallel port mask.

Parameters:
- NUM_PORTS, 8: width of the reconstructed vector. Legal range is 2 to 256.
- POS_W, $clog2(NUM_PORTS): width of a position index. Derived; never overridden.
- CNT_W, $clog2(NUM_PORTS+1): width of the set-bit count. Derived.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  position beat valid.
- in_ready  out  1  position beat accepted when in_valid & in_ready.
- in_pos  in  POS_W  bit index to set. Bit 0 is the LSB of out_vec.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_vec  out  NUM_PORTS  reconstructed vector.
- out_count  out  CNT_W  number of distinct bits set in out_vec.
- out_err_dup  out  1  the frame contained a repeated position.
- out_err_range  out  1  the frame contained in_pos >= NUM_PORTS. This is only possible when NUM_PORTS is not a power of 2.

Behaviour:
- Reset is sampled at the clock edge while rst_n=0. Reset values:
  - out_valid=0, out_vec=0, out_count=0, out_err_dup=0, out_err_range=0.
  - Accumulator vector, count and error flags cleared; FSM goes to COLLECT.
- Reset mid-frame or mid-hold discards the partial frame and any pending result. No output is produced for it.
- FSM has two states:
  - COLLECT: in_ready=1.
  - FULL: a result is held and in_ready=out_ready (pass-through).
- in_ready never depends on in_valid, in_pos or in_last.
- Accepted beat, no last: updates the accumulator only.
  - In range and bit clear: set the bit and increment the count.
  - In range and bit already set: sticky dup flag set; vector and count unchanged.
  - Out of range: sticky range flag set; vector and count unchanged.
- Accepted beat with in_last:
  - The beat's own update is merged first.
  - The merged vector, count and flags load into the output registers on the same edge.
  - out_valid=1 the next cycle: 1-cycle latency from the last beat to the result.
  - Accumulator, count and flags clear on the same edge, ready for the next frame.
  - FSM goes to FULL.
- FULL with out_valid & out_ready:
  - If no last beat is accepted that cycle: out_valid drops next cycle and the FSM returns to COLLECT.
  - If a last beat is accepted the same cycle: the new result replaces the old one with no bubble; out_valid stays 1 and the FSM stays in FULL.
- Non-last beats accepted in FULL (in_ready=out_ready=1) update the accumulator normally.
- Outputs are stable while out_valid=1 and out_ready=0.
- A single-beat frame is legal: the vector has one bit set, or is zero with err_range set if the position is out of range.
- Counter width CNT_W cannot overflow, because duplicates do not increment the count.
- All outputs are registered; there is no combinational path from in_* to out_*.

Test Plan (NUM_PORTS=8 unless noted):
- Frame pos 0, 3, 7 (last on 7), out_ready=1 → one cycle after the last beat: out_vec=8'h89, out_count=3, both errs 0, out_valid high exactly 1 cycle.
- Frame 2, 5, 2 (last) → out_vec=8'h24, out_count=2, out_err_dup=1; the next frame {1} gives out_vec=8'h02 with errs cleared.
- NUM_PORTS=6: frame 1, 6 (last) → out_vec=6'h02, out_count=1, out_err_range=1.
- Backpressure: out_ready=0 after frame {4}, then frame 0, 1 (last) offered → in_ready=0 during hold, out_vec=8'h10 stable. Release out_ready → 8'h10 accepted, then 8'h03 presented, no beat lost.
- Back-to-back single-beat frames 6, 3, 0 with out_ready=1 every cycle → out_valid continuously high for 3 cycles, vectors 8'h40, 8'h08, 8'h01.
- Assert rst_n=0 for 1 cycle after beats 1, 2 of a frame, then send frame {5} → no partial output appears; out_vec=8'h20, out_count=1.
